// File: rtl/digit_serial_comparator.sv
// Digit-serial magnitude comparator: scans two WIDTH-bit operands MSB-first, DIGIT bits per clock.
// Optional build macro DIGIT_CMP_EARLY_EXIT_EN stops the scan at the first differing digit.
module digit_serial_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WIDTH-1:0]                a,
    input  logic [WIDTH-1:0]                b,
    input  logic                            signed_mode,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            a_larger,
    output logic                            b_larger,
    output logic                            equal,
    output logic [WIDTH-1:0]                diff_mask,
    output logic [$clog2(WIDTH/DIGIT):0]    scan_cycles,
    output logic [1:0]                      dbg_state
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int SCW  = $clog2(NDIG) + 1;
    localparam int KW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready is high only in IDLE; out_valid is high only in DONE and holds until out_ready.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [KW-1:0]      r_k;
    logic               r_found;
    logic               r_gt;
    logic               r_out_valid;
    logic               r_a_larger;
    logic               r_b_larger;
    logic               r_equal;
    logic [WIDTH-1:0]   r_diff_mask;
    logic [SCW-1:0]     r_scan_cycles;

    logic [DIGIT-1:0]   w_dig_a;
    logic [DIGIT-1:0]   w_dig_b;
    logic               w_dig_ne;
    logic               w_dig_gt;
    logic               w_last;
    logic               w_diff_seen;
    logic               w_a_gt;
    logic               w_decide;

    // The operand registers shift left each scan cycle, so the current digit is always on top.
    assign w_dig_a     = r_a[WIDTH-1 -: DIGIT];
    assign w_dig_b     = r_b[WIDTH-1 -: DIGIT];
    assign w_dig_ne    = (w_dig_a != w_dig_b);
    assign w_dig_gt    = (w_dig_a > w_dig_b);
    assign w_last      = (r_k == KW'(NDIG - 1));
    assign w_diff_seen = r_found | w_dig_ne;
    assign w_a_gt      = r_found ? r_gt : w_dig_gt;

`ifdef DIGIT_CMP_EARLY_EXIT_EN
    assign w_decide = w_dig_ne | w_last;
`else
    assign w_decide = w_last;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_a           <= '0;
            r_b           <= '0;
            r_k           <= '0;
            r_found       <= 1'b0;
            r_gt          <= 1'b0;
            r_out_valid   <= 1'b0;
            r_a_larger    <= 1'b0;
            r_b_larger    <= 1'b0;
            r_equal       <= 1'b0;
            r_diff_mask   <= '0;
            r_scan_cycles <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        // Flipping both sign bits turns a two's-complement compare into an unsigned one.
                        r_a         <= signed_mode ? (a ^ MSB_MASK) : a;
                        r_b         <= signed_mode ? (b ^ MSB_MASK) : b;
                        r_diff_mask <= a ^ b;
                        r_k         <= '0;
                        r_found     <= 1'b0;
                        r_gt        <= 1'b0;
                        r_state     <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // Only the first differing digit decides; later digits are ignored.
                    if (!r_found && w_dig_ne) begin
                        r_found <= 1'b1;
                        r_gt    <= w_dig_gt;
                    end
                    if (w_decide) begin
                        r_a_larger    <= w_diff_seen & w_a_gt;
                        r_b_larger    <= w_diff_seen & ~w_a_gt;
                        r_equal       <= ~w_diff_seen;
                        r_scan_cycles <= SCW'(r_k) + SCW'(1);
                        r_out_valid   <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_k <= r_k + KW'(1);
                        r_a <= r_a << DIGIT;
                        r_b <= r_b << DIGIT;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign out_valid   = r_out_valid;
    assign a_larger    = r_a_larger;
    assign b_larger    = r_b_larger;
    assign equal       = r_equal;
    assign diff_mask   = r_diff_mask;
    assign scan_cycles = r_scan_cycles;
    assign dbg_state   = r_state;

endmodule
